alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the datapath execute stage, the successor to the 8-bit combinational ALU. It widens the opcode set to 4 bits, adds signed compare, subtract, OR and arithmetic shift, and adds an iterative multiplier and iterative shifter. Operand transfer and result transfer each use a valid/ready handshake. The result and a four-bit flag set are held in registers until the consumer accepts them.

## Interface
- `WIDTH`, default 8: operand/result width, must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the iteration counter, derived; do not override.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  opcode/operands valid.
- `in_ready`  out  1  block can accept an operation.
- `alu_opcode`  in  4  operation code (`alu_op_e`).
- `alu_input_a`  in  WIDTH  first operand.
- `alu_input_b`  in  WIDTH  second operand; shift amount for shifts.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts the result.
- `alu_out`  out  WIDTH  result.
- `flag_zero`, `flag_carry`, `flag_negative`, `flag_overflow`  out  1 each  status flags.
- `op_illegal`  out  1  reserved opcode executed; qualified by `out_valid`.

## Operation
- Opcodes:
  - 0 AND
  - 1 ADD
  - 2 XOR
  - 3 SLTU (a<b unsigned → 1, else 0)
  - 4 SLL
  - 5 SRL
  - 6 SNE
  - 7 SUB (a−b)
  - 8 OR
  - 9 SRA
  - 10 SLT (signed)
  - 11 MUL (low WIDTH bits of the unsigned product)
  - 12–15 reserved
- FSM states are IDLE, BUSY and DONE. `in_ready` = (state==IDLE). Operands and opcode are captured on the accept edge; later changes on the inputs are ignored.
- IDLE → DONE for single-cycle ops (0–3, 6–8, 10, reserved) and for shifts with n=0.
- IDLE → BUSY for shifts with n>0 and for MUL.
- BUSY → DONE when the counter reaches 0.
- DONE → IDLE on `out_ready`.
- Shifts: n = min(b, WIDTH), with b treated as unsigned. The shifter moves one bit per BUSY cycle.
  - b ≥ WIDTH gives 0 for SLL/SRL and all sign bits for SRA.
- MUL: shift-add, one partial product per BUSY cycle, exactly WIDTH cycles. A 2·WIDTH accumulator is kept internally.
- Reserved opcodes: `alu_out`=0, `flag_zero`=1, all other flags 0, `op_illegal`=1.
- Flags are computed on the final result:
  - `zero` = (result==0).
  - `negative` = result[WIDTH−1].
  - `carry`:
    - ADD: carry-out.
    - SUB: 1 when a ≥ b unsigned, i.e. no borrow.
    - SLL/SRL/SRA: the last bit shifted out, 0 when n=0.
    - MUL: 1 when the high half of the product ≠ 0.
    - Otherwise 0.
  - `overflow` = signed overflow for ADD/SUB, otherwise 0.

## Timing
- Let the accept edge be cycle 0. `out_valid` rises after the edge at cycle L:
  - L=1 for single-cycle ops.
  - L=1+n for shifts.
  - L=1+WIDTH for MUL.
- In DONE, `alu_out`, the flags and `op_illegal` stay constant for as long as `out_valid && !out_ready`.
- `out_ready` that is high while `out_valid` is low has no effect.
- `in_ready` is low throughout BUSY and DONE. The output handshake and a new input accept never occur in the same cycle. Peak throughput is one single-cycle op per 2 cycles.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `alu_out`=0, all flags 0, `op_illegal`=0, counter and accumulator 0.
- Reset asserted mid-operation clears everything immediately. No partial result is ever presented.
- `out_ready` held permanently high: DONE lasts exactly 1 cycle.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` (4-bit enum, values as above).
  - `alu_state_e` {IDLE, BUSY, DONE}.
  - `alu_flags_t` packed struct {zero, carry, negative, overflow}.
  - Helper `is_multicycle(op)`.
- Sub-module `alu_comb_core` (parameter WIDTH): purely combinational single-cycle ops plus flag generation.
- The FSM, iterative shifter and multiplier live in `alu_mc`.

## Test plan
All scenarios use WIDTH=8.
- ADD 0xFF+0x01 → `alu_out`=0x00, zero=1, carry=1, overflow=0, `out_valid` at cycle 1.
- SUB 0x80−0x01 → 0x7F, overflow=1, carry=1, negative=0. Then SLT 0x80,0x01 → 1 and SLTU 0x80,0x01 → 0.
- Shifts:
  - SLL 0x81 by 1 → 0x02, carry=1, L=2.
  - SRA 0x90 by 3 → 0xF2, carry=0, L=4.
  - SRL 0xFF by 200 → 0x00, carry=1, L=9.
- MUL 0x10×0x11 → 0x10, carry=1, L=9. MUL 0x0F×0x0F → 0xE1, carry=0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises → outputs stable and `in_ready`=0 throughout; accept on release; next op accepted the cycle after. Opcode 13 → `op_illegal`=1, zero=1.
- Assert `rst_n` low at cycle 4 of a MUL → outputs at reset values immediately; after release `in_ready`=1; a subsequent ADD 0x02+0x03 returns 0x05.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the multi-cycle ALU: opcode encoding, FSM state encoding,
// the packed flag set and small opcode classification helpers.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_ADD   = 4'd1,
        OP_XOR   = 4'd2,
        OP_SLTU  = 4'd3,
        OP_SLL   = 4'd4,
        OP_SRL   = 4'd5,
        OP_SNE   = 4'd6,
        OP_SUB   = 4'd7,
        OP_OR    = 4'd8,
        OP_SRA   = 4'd9,
        OP_SLT   = 4'd10,
        OP_MUL   = 4'd11,
        OP_RSV12 = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } alu_flags_t;

    // Ops that may need the iterative datapath (shifts by 0 still finish at once).
    function automatic logic is_multicycle(alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_MUL);
    endfunction

    function automatic logic is_shift(alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
// Purely combinational evaluation of the single-cycle opcodes plus flag
// generation. Shift and multiply opcodes return 0 here; they are produced by
// the iterative datapath in alu_mc. Reserved opcodes yield 0 with illegal_o=1.
//   op_i      opcode
//   a_i, b_i  operands
//   result_o  WIDTH-bit result
//   flags_o   {zero, carry, negative, overflow} of result_o
//   illegal_o reserved opcode
// -----------------------------------------------------------------------------
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_e            op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   result_o,
    output alu_flags_t         flags_o,
    output logic               illegal_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             illegal;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = a_i - b_i;

    always_comb begin
        result  = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (op_i)
            OP_AND:  result = a_i & b_i;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            OP_XOR:  result = a_i ^ b_i;
            OP_SLTU: result[0] = (a_i < b_i);
            OP_SNE:  result[0] = (a_i != b_i);
            OP_SUB: begin
                result = diff;
                carry  = (a_i >= b_i);  // carry means "no borrow"
                ovf    = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            OP_OR:   result = a_i | b_i;
            OP_SLT:  result[0] = ($signed(a_i) < $signed(b_i));
            OP_SLL, OP_SRL, OP_SRA, OP_MUL: result = '0;
            default: illegal = 1'b1;
        endcase
    end

    assign result_o           = result;
    assign flags_o.zero       = (result == '0);
    assign flags_o.carry      = carry;
    assign flags_o.negative   = result[MSB];
    assign flags_o.overflow   = ovf;
    assign illegal_o          = illegal;

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU with valid/ready handshakes on operand and result transfer.
// Single-cycle ops complete on the accept edge; shifts move one bit per BUSY
// cycle; MUL is a shift-add multiplier taking exactly WIDTH BUSY cycles.
// Result, flags and op_illegal are registered and held until accepted.
//   clk, rst_n                       clock, async active-low reset
//   in_valid / in_ready              operand handshake
//   alu_opcode, alu_input_a/_b       operation and operands
//   out_valid / out_ready            result handshake
//   alu_out, flag_*, op_illegal      registered result and status
// -----------------------------------------------------------------------------
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_opcode,
    input  logic [WIDTH-1:0]   alu_input_a,
    input  logic [WIDTH-1:0]   alu_input_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   alu_out,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_negative,
    output logic               flag_overflow,
    output logic               op_illegal
);

    localparam int               MSB   = WIDTH - 1;
    localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    alu_state_e         state_q, state_d;
    alu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   sh_q, sh_d;       // shift working register / multiplicand
    logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial high half, remaining multiplier}
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    alu_flags_t         flags_q, flags_d;
    logic               illegal_q, illegal_d;

    alu_op_e            op_in;
    logic [CNT_W-1:0]   n_in;
    logic [WIDTH-1:0]   core_res;
    alu_flags_t         core_flags;
    logic               core_ill;

    logic [WIDTH-1:0]   sh_step;
    logic               sh_out_bit;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step;

    assign op_in = alu_op_e'(alu_opcode);
    // Shift amount saturates at WIDTH; below that it always fits in CNT_W bits.
    assign n_in  = (alu_input_b >= W_LIM) ? W_CNT : alu_input_b[CNT_W-1:0];

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op_i      (op_in),
        .a_i       (alu_input_a),
        .b_i       (alu_input_b),
        .result_o  (core_res),
        .flags_o   (core_flags),
        .illegal_o (core_ill)
    );

    // One-bit shift step on the working register.
    always_comb begin
        sh_step    = sh_q;
        sh_out_bit = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_step    = {sh_q[MSB-1:0], 1'b0};
                sh_out_bit = sh_q[MSB];
            end
            OP_SRL: begin
                sh_step    = {1'b0, sh_q[MSB:1]};
                sh_out_bit = sh_q[0];
            end
            OP_SRA: begin
                sh_step    = {sh_q[MSB], sh_q[MSB:1]};
                sh_out_bit = sh_q[0];
            end
            default: ;
        endcase
    end

    // Shift-right multiplier: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, sh_q} : '0);
    assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = op_in;
                    if (is_multicycle(op_in) && !(is_shift(op_in) && (n_in == '0))) begin
                        state_d = BUSY;
                        sh_d    = alu_input_a;
                        acc_d   = {{WIDTH{1'b0}}, alu_input_b};
                        cnt_d   = (op_in == OP_MUL) ? W_CNT : n_in;
                    end else begin
                        state_d = DONE;
                        if (is_shift(op_in)) begin
                            // Shift by zero: operand passes through, nothing shifted out.
                            out_d            = alu_input_a;
                            flags_d.zero     = (alu_input_a == '0);
                            flags_d.carry    = 1'b0;
                            flags_d.negative = alu_input_a[MSB];
                            flags_d.overflow = 1'b0;
                            illegal_d        = 1'b0;
                        end else begin
                            out_d     = core_res;
                            flags_d   = core_flags;
                            illegal_d = core_ill;
                        end
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - ONE;
                if (op_q == OP_MUL) begin
                    acc_d = acc_step;
                end else begin
                    sh_d = sh_step;
                end
                if (cnt_q == ONE) begin
                    state_d          = DONE;
                    illegal_d        = 1'b0;
                    flags_d.overflow = 1'b0;
                    if (op_q == OP_MUL) begin
                        out_d            = acc_step[WIDTH-1:0];
                        flags_d.zero     = (acc_step[WIDTH-1:0] == '0);
                        flags_d.carry    = |acc_step[2*WIDTH-1:WIDTH];
                        flags_d.negative = acc_step[MSB];
                    end else begin
                        out_d            = sh_step;
                        flags_d.zero     = (sh_step == '0);
                        flags_d.carry    = sh_out_bit;
                        flags_d.negative = sh_step[MSB];
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_AND;
            sh_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign alu_out       = out_q;
    assign flag_zero     = flags_q.zero;
    assign flag_carry    = flags_q.carry;
    assign flag_negative = flags_q.negative;
    assign flag_overflow = flags_q.overflow;
    assign op_illegal    = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] alu_opcode = '0;
    logic [7:0] alu_input_a = '0;
    logic [7:0] alu_input_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] alu_out;
    logic       flag_zero, flag_carry, flag_negative, flag_overflow;
    logic       op_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] zcnv;
        logic       ill;
        int         lat;
    } exp_t;

    exp_t sb[$];

    alu_mc #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_opcode    (alu_opcode),
        .alu_input_a   (alu_input_a),
        .alu_input_b   (alu_input_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_out       (alu_out),
        .flag_zero     (flag_zero),
        .flag_carry    (flag_carry),
        .flag_negative (flag_negative),
        .flag_overflow (flag_overflow),
        .op_illegal    (op_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {flag_zero, flag_carry, flag_negative, flag_overflow};
    endfunction

    task automatic scramble_inputs();
        alu_opcode  = 4'($urandom);
        alu_input_a = 8'($urandom);
        alu_input_b = 8'($urandom);
    endtask

    // Drive one operation (called just after a posedge) and push its expectation.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic [3:0] zcnv, input logic ill,
                         input int lat);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.res = res; e.zcnv = zcnv; e.ill = ill; e.lat = lat;
        sb.push_back(e);
        chk("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        alu_opcode  = op;
        alu_input_a = a;
        alu_input_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Wait for the result, compare against the scoreboard head, then handshake.
    task automatic collect(input int stall, input bit early_ready);
        exp_t e;
        int lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            chk("in_ready_low_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("latency", 32'(lat), 32'(e.lat));
        chk("alu_out", 32'(alu_out), 32'(e.res));
        chk("flags_zcnv", 32'(flags_now()), 32'(e.zcnv));
        chk("op_illegal", 32'(op_illegal), 32'(e.ill));
        chk("in_ready_low_done", 32'(in_ready), 32'd0);
        $display("[TB] op=%0d a=%h b=%h -> out=%h zcnv=%b ill=%b lat=%0d",
                 e.op, e.a, e.b, alu_out, flags_now(), op_illegal, lat);
        if (early_ready) begin
            @(posedge clk);
            #1;
            chk("done_one_cycle", 32'(out_valid), 32'd0);
            out_ready = 1'b0;
        end else begin
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'b1;           // must be ignored while in_ready is low
                scramble_inputs();
                @(posedge clk);
                #1;
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_out", 32'(alu_out), 32'(e.res));
                chk("stall_flags", 32'(flags_now()), 32'(e.zcnv));
                chk("stall_ill", 32'(op_illegal), 32'(e.ill));
                chk("stall_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("released_valid", 32'(out_valid), 32'd0);
        end
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic [3:0] zcnv, input logic ill,
                       input int lat);
        issue(op, a, b, res, zcnv, ill, lat);
        collect(0, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_out", 32'(alu_out), 32'd0);
        chk("rst_flags", 32'(flags_now()), 32'd0);
        chk("rst_ill", 32'(op_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //  op   a      b      res    zcnv     ill lat
        run(4'd1,  8'hFF, 8'h01, 8'h00, 4'b1100, 0, 1);   // ADD wrap
        run(4'd7,  8'h80, 8'h01, 8'h7F, 4'b0101, 0, 1);   // SUB overflow
        run(4'd10, 8'h80, 8'h01, 8'h01, 4'b0000, 0, 1);   // SLT signed
        run(4'd3,  8'h80, 8'h01, 8'h00, 4'b1000, 0, 1);   // SLTU
        run(4'd1,  8'h7F, 8'h01, 8'h80, 4'b0011, 0, 1);   // ADD signed overflow
        run(4'd7,  8'h01, 8'h02, 8'hFF, 4'b0010, 0, 1);   // SUB with borrow
        run(4'd0,  8'hF0, 8'h3C, 8'h30, 4'b0000, 0, 1);   // AND
        run(4'd8,  8'h50, 8'h0A, 8'h5A, 4'b0000, 0, 1);   // OR
        run(4'd6,  8'h05, 8'h05, 8'h00, 4'b1000, 0, 1);   // SNE equal
        run(4'd4,  8'h81, 8'h01, 8'h02, 4'b0100, 0, 2);   // SLL by 1
        run(4'd9,  8'h90, 8'h03, 8'hF2, 4'b0010, 0, 4);   // SRA by 3
        run(4'd5,  8'hFF, 8'd200, 8'h00, 4'b1100, 0, 9);  // SRL saturated
        run(4'd9,  8'h80, 8'h09, 8'hFF, 4'b0110, 0, 9);   // SRA saturated
        run(4'd4,  8'h81, 8'h00, 8'h81, 4'b0010, 0, 1);   // SLL by 0
        run(4'd11, 8'h10, 8'h11, 8'h10, 4'b0100, 0, 9);   // MUL high half nonzero
        run(4'd11, 8'h0F, 8'h0F, 8'hE1, 4'b0010, 0, 9);   // MUL fits

        // Backpressure for 5 cycles, then the next op immediately after release
        issue(4'd2, 8'hA5, 8'h3C, 8'h99, 4'b0010, 0, 1);  // XOR
        collect(5, 1'b0);
        run(4'd13, 8'h12, 8'h34, 8'h00, 4'b1000, 1, 1);   // reserved opcode

        // out_ready held high the whole time: DONE lasts one cycle
        out_ready = 1'b1;
        issue(4'd11, 8'h03, 8'h05, 8'h0F, 4'b0000, 0, 9);
        collect(0, 1'b1);

        // Leave a nonzero result in the output registers, then reset mid-MUL
        run(4'd7, 8'h01, 8'h02, 8'hFF, 4'b0010, 0, 1);
        in_valid    = 1'b1;
        alu_opcode  = 4'd11;
        alu_input_a = 8'h10;
        alu_input_b = 8'h11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_alu_out", 32'(alu_out), 32'd0);
        chk("midrst_flags", 32'(flags_now()), 32'd0);
        chk("midrst_ill", 32'(op_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_result", 32'(out_valid), 32'd0);
        end
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        run(4'd1, 8'h02, 8'h03, 8'h05, 4'b0000, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
